// File: rtl/uart_stream_rx.sv
// uart_stream_rx: 8N1 UART receiver (start low, 8 data bits MSB first,
// stop high) presenting each received byte on a valid/ready stream port.
//
// Optional feature: define UART_RX_MAJORITY_EN to replace the single
// mid-bit sample with a 2-of-3 majority vote over the nominal sample
// point and its two neighbours. The vote is resolved one clock after the
// nominal point, so every decision (and m_valid) moves one clock later,
// and a single-cycle glitch at mid-bit is rejected.
//
// Timing (t0 = first clk edge that registers rx low in the synchroniser):
// the byte appears on m_valid after edge t0 + 2 + HALF_BIT + 9*CLKS_PER_BIT + 1
// (+1 with UART_RX_MAJORITY_EN). frame_err / overrun pulse on that cycle.

module uart_stream_rx #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);

`ifdef UART_RX_MAJORITY_EN
  localparam int DECIDE_LAG = 1;
`else
  localparam int DECIDE_LAG = 0;
`endif

  // Start-bit decision lands HALF_BIT clocks into START (plus the vote lag);
  // data and stop decisions follow at whole bit periods after that.
  localparam logic [CW-1:0] START_LAST = CW'(HALF_BIT + DECIDE_LAG);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // Synchroniser and sampled line
  logic          r_sync1;
  logic          r_sync2;
  logic          w_rxS;
  logic          w_sample;

  // Receiver state and datapath
  state_t        r_state;
  state_t        w_stateNext;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cntNext;
  logic [2:0]    r_bitIdx;
  logic [2:0]    w_bitIdxNext;
  logic [7:0]    r_shReg;
  logic [7:0]    w_shRegNext;
  logic          r_armed;
  logic          w_armedNext;

  // Output registers
  logic [7:0]    r_mData;
  logic [7:0]    w_mDataNext;
  logic          r_mValid;
  logic          w_mValidNext;
  logic          r_frameErr;
  logic          w_frameErrNext;
  logic          r_overrun;
  logic          w_overrunNext;

  assign w_rxS = r_sync2;

  // Two-flop synchroniser; idles high so reset looks like an idle line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;

  // Keep the two previous synchronised samples for the 2-of-3 vote
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], w_rxS};
    end
  end

  assign w_sample = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rxS) |
                    (r_hist[0] & w_rxS);
`else
  assign w_sample = w_rxS;
`endif

  // Receiver and output registers; reset drops any partial frame at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bitIdx   <= 3'd0;
      r_shReg    <= 8'h00;
      r_armed    <= 1'b0;
      r_mData    <= 8'h00;
      r_mValid   <= 1'b0;
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_cnt      <= w_cntNext;
      r_bitIdx   <= w_bitIdxNext;
      r_shReg    <= w_shRegNext;
      r_armed    <= w_armedNext;
      r_mData    <= w_mDataNext;
      r_mValid   <= w_mValidNext;
      r_frameErr <= w_frameErrNext;
      r_overrun  <= w_overrunNext;
    end
  end

  // Next-state, bit timing, shifting and stream handshake
  always_comb begin
    w_stateNext    = r_state;
    w_cntNext      = r_cnt + 1'b1;
    w_bitIdxNext   = r_bitIdx;
    w_shRegNext    = r_shReg;
    w_armedNext    = 1'b0;
    w_mDataNext    = r_mData;
    w_mValidNext   = r_mValid & ~m_ready;
    w_frameErrNext = 1'b0;
    w_overrunNext  = 1'b0;

    case (r_state)
      S_IDLE: begin
        // A start is only recognised once the line has been seen high,
        // so a line stuck low after a bad stop bit cannot retrigger.
        w_cntNext    = '0;
        w_bitIdxNext = 3'd0;
        w_armedNext  = r_armed | w_rxS;
        if (r_armed && !w_rxS) begin
          w_stateNext = S_START;
        end
      end

      S_START: begin
        if (r_cnt == START_LAST) begin
          w_cntNext    = '0;
          w_bitIdxNext = 3'd0;
          if (w_sample) begin
            w_stateNext = S_IDLE;
          end else begin
            w_stateNext = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cntNext   = '0;
          w_shRegNext = {r_shReg[6:0], w_sample};
          if (r_bitIdx == 3'd7) begin
            w_stateNext = S_STOP;
          end else begin
            w_bitIdxNext = r_bitIdx + 3'd1;
          end
        end
      end

      S_STOP: begin
        // Leaving at mid-stop-bit lets a back-to-back start be caught.
        if (r_cnt == BIT_LAST) begin
          w_cntNext   = '0;
          w_stateNext = S_IDLE;
          if (w_sample) begin
            if (!r_mValid || m_ready) begin
              w_mDataNext  = r_shReg;
              w_mValidNext = 1'b1;
            end else begin
              w_overrunNext = 1'b1;
            end
          end else begin
            w_frameErrNext = 1'b1;
          end
        end
      end

      default: begin
        w_stateNext = S_IDLE;
        w_cntNext   = '0;
      end
    endcase
  end

  assign m_data    = r_mData;
  assign m_valid   = r_mValid;
  assign frame_err = r_frameErr;
  assign overrun   = r_overrun;

endmodule
